// File: rtl/datmem_pkg.sv
// ============================================================================
// datmem_pkg : shared types and default sizes for Datmem and its arbiter
// Revision   : 1.0
// ============================================================================
`default_nettype none

package datmem_pkg;

  localparam int C_AWIDTH  = 32;
  localparam int C_ALENGTH = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } datmem_state_t;

endpackage

`default_nettype wire

// File: rtl/datmem_arbiter_rr_arb2.sv
// ============================================================================
// rr_arb2 : combinational two-way round-robin pick
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = req0 | req1;
    // On a tie the port that did not win last time goes first.
    if (req0 && req1) begin
      gnt_id = ~last;
    end else begin
      gnt_id = req1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/datmem_arbiter.sv
// ============================================================================
// datmem_arbiter : two-port arbiter and IDLE/ACCESS/RESP sequencer for Datmem
// Revision       : 1.0
// ============================================================================
`default_nettype none

module datmem_arbiter
  import datmem_pkg::*;
#(
  parameter int AWIDTH  = C_AWIDTH,
  parameter int ALENGTH = C_ALENGTH
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              We0,
  input  logic              We1,
  input  logic [AWIDTH-1:0] Addr0,
  input  logic [AWIDTH-1:0] Addr1,
  input  logic [AWIDTH-1:0] WDat0,
  input  logic [AWIDTH-1:0] WDat1,
  output logic              Ack0,
  output logic              Ack1,
  output logic [AWIDTH-1:0] RDat0,
  output logic [AWIDTH-1:0] RDat1,
  output logic              Err0,
  output logic              Err1,
  output logic [AWIDTH-1:0] Addr,
  output logic [AWIDTH-1:0] WriDat,
  output logic              WE2,
  input  logic [AWIDTH-1:0] ReaDat
);

  datmem_state_t     r_state;
  datmem_state_t     w_next;
  logic              r_last;
  logic              r_id;
  logic              r_we;
  logic              r_oor;
  logic [AWIDTH-1:0] r_addr;
  logic [AWIDTH-1:0] r_wdat;
  logic [AWIDTH-1:0] r_rdat0;
  logic [AWIDTH-1:0] r_rdat1;

  logic              w_gnt_valid;
  logic              w_gnt_id;
  logic              w_we;
  logic [AWIDTH-1:0] w_addr;
  logic [AWIDTH-1:0] w_wdat;
  logic              w_oor;
  logic [AWIDTH-1:0] w_cap;

  rr_arb2 u_arb (
    .req0      (Req0),
    .req1      (Req1),
    .last      (r_last),
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id)
  );

  assign w_we   = w_gnt_id ? We1   : We0;
  assign w_addr = w_gnt_id ? Addr1 : Addr0;
  assign w_wdat = w_gnt_id ? WDat1 : WDat0;
  assign w_oor  = (w_addr >= AWIDTH'(ALENGTH));
  assign w_cap  = (r_we || r_oor) ? '0 : ReaDat;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_gnt_valid) w_next = ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_last  <= 1'b1;
      r_id    <= 1'b0;
      r_we    <= 1'b0;
      r_oor   <= 1'b0;
      r_addr  <= '0;
      r_wdat  <= '0;
      r_rdat0 <= '0;
      r_rdat1 <= '0;
    end else begin
      if (r_state == IDLE && w_gnt_valid) begin
        r_last <= w_gnt_id;
        r_id   <= w_gnt_id;
        r_we   <= w_we;
        r_oor  <= w_oor;
        r_addr <= w_addr;
        r_wdat <= w_wdat;
      end
      if (r_state == ACCESS) begin
        if (r_id) begin
          r_rdat1 <= w_cap;
        end else begin
          r_rdat0 <= w_cap;
        end
      end
    end
  end

  // Memory-side signals are forced to zero outside ACCESS so no stray write can occur.
  always_comb begin
    Addr   = '0;
    WriDat = '0;
    WE2    = 1'b0;
    Ack0   = 1'b0;
    Ack1   = 1'b0;
    Err0   = 1'b0;
    Err1   = 1'b0;
    case (r_state)
      ACCESS: begin
        Addr   = r_addr;
        WriDat = r_wdat;
        WE2    = r_we & ~r_oor;
      end
      RESP: begin
        Ack0 = ~r_id;
        Ack1 = r_id;
        Err0 = ~r_id & r_oor;
        Err1 = r_id & r_oor;
      end
      default: ;
    endcase
  end

  assign RDat0 = r_rdat0;
  assign RDat1 = r_rdat1;

endmodule

`default_nettype wire

// File: tb/tb_datmem_arbiter.sv
// ============================================================================
// tb_datmem_arbiter : scoreboard bench with a Datmem model and a reference model
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_datmem_arbiter;

  localparam int AL = 128;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Req0 = 1'b0, Req1 = 1'b0, We0 = 1'b0, We1 = 1'b0;
  logic [31:0] Addr0 = '0, Addr1 = '0, WDat0 = '0, WDat1 = '0;
  logic        Ack0, Ack1, Err0, Err1, WE2;
  logic [31:0] RDat0, RDat1, Addr, WriDat, ReaDat;

  datmem_arbiter #(.AWIDTH(32), .ALENGTH(AL)) dut (
    .CLK(CLK), .RST(RST),
    .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
    .Addr0(Addr0), .Addr1(Addr1), .WDat0(WDat0), .WDat1(WDat1),
    .Ack0(Ack0), .Ack1(Ack1), .RDat0(RDat0), .RDat1(RDat1),
    .Err0(Err0), .Err1(Err1),
    .Addr(Addr), .WriDat(WriDat), .WE2(WE2), .ReaDat(ReaDat)
  );

  always #5 CLK = ~CLK;

  // Datmem stand-in: level write on the rising edge, combinational read.
  bit [31:0] dmem [AL];
  always @(posedge CLK) if (WE2 && Addr < AL) dmem[Addr[6:0]] <= WriDat;
  assign ReaDat = (Addr < AL) ? dmem[Addr[6:0]] : 32'h0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        err;
  } exp_t;

  exp_t      exp0[$];
  exp_t      exp1[$];
  int        ack_order[$];
  bit        record_order = 1'b0;
  bit [31:0] ref_mem [AL];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, we_cyc = -100, we_total = 0, exp_we_total = 0, ack_count = 0;
  logic [31:0] we_addr = '0, we_dat = '0;
  logic prev_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_ack(input int p, input logic [31:0] rd, input logic er);
    exp_t e;
    if ((p == 0 && exp0.size() == 0) || (p == 1 && exp1.size() == 0)) begin
      n_tests++;
      n_fail++;
      $display("FAIL spurious_ack%0d: got ack expected none (cycle %0d)", p, cyc);
      return;
    end
    if (p == 0) e = exp0.pop_front();
    else        e = exp1.pop_front();
    if (record_order) ack_order.push_back(p);
    chk($sformatf("rdat%0d", p), rd, e.rdat);
    chk($sformatf("err%0d", p), {31'b0, er}, {31'b0, e.err});
    if (e.we && !e.err) begin
      chk("we2_cycle", we_cyc, cyc - 1);
      chk("we2_addr", we_addr, e.addr);
      chk("we2_data", we_dat, e.wdat);
      exp_we_total++;
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Monitor: pops the scoreboard whenever an Ack appears.
  initial forever begin
    @(negedge CLK);
    if (RST) begin
      prev_we = 1'b0;
    end else begin
      if (WE2) begin
        chk("we2_single_cycle", {31'b0, prev_we}, 32'h0);
        chk("we2_in_range", {31'b0, (Addr >= AL)}, 32'h0);
        we_cyc  = cyc;
        we_addr = Addr;
        we_dat  = WriDat;
        we_total++;
      end
      prev_we = WE2;
      if (Ack0 && Ack1) chk("ack_overlap", 32'h1, 32'h0);
      if (Ack0 || Ack1) ack_count++;
      if (Ack0) check_ack(0, RDat0, Err0);
      if (Ack1) check_ack(1, RDat1, Err1);
    end
  end

  // Reference model: each port is sequential, so resolving memory state at issue time is exact.
  task automatic access(input int p, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input int lat);
    exp_t e;
    int   n;
    logic got;
    e.we = we; e.addr = a; e.wdat = d; e.err = (a >= AL); e.rdat = '0;
    if (!e.err) begin
      if (we) ref_mem[a[6:0]] = d;
      else    e.rdat = ref_mem[a[6:0]];
    end
    if (p == 0) exp0.push_back(e);
    else        exp1.push_back(e);
    @(negedge CLK);
    if (p == 0) begin Req0 = 1'b1; We0 = we; Addr0 = a; WDat0 = d; end
    else        begin Req1 = 1'b1; We1 = we; Addr1 = a; WDat1 = d; end
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge CLK);
      n++;
      got = (p == 0) ? Ack0 : Ack1;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL ack_timeout%0d: got no ack expected ack within 40 cycles", p);
    end else if (lat > 0) begin
      chk($sformatf("latency%0d", p), n, lat);
    end
    if (p == 0) Req0 = 1'b0;
    else        Req1 = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ack0"}, {31'b0, Ack0}, 32'h0);
    chk({tag, "_ack1"}, {31'b0, Ack1}, 32'h0);
    chk({tag, "_err0"}, {31'b0, Err0}, 32'h0);
    chk({tag, "_err1"}, {31'b0, Err1}, 32'h0);
    chk({tag, "_we2"}, {31'b0, WE2}, 32'h0);
    chk({tag, "_addr"}, Addr, 32'h0);
    chk({tag, "_wridat"}, WriDat, 32'h0);
    chk({tag, "_rdat0"}, RDat0, 32'h0);
    chk({tag, "_rdat1"}, RDat1, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; Req0 = 1'b0; Req1 = 1'b0;
    repeat (2) @(negedge CLK);
    check_outputs_zero("reset");
    RST = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr(input int p);
    int r;
    r = $urandom_range(9, 0);
    if (r == 0) return 32'(AL) + 32'($urandom_range(1000, 0));
    if (r == 1) return {1'b1, 31'($urandom)};
    return (p == 0) ? 32'($urandom_range(63, 0)) : 32'($urandom_range(127, 64));
  endfunction

  initial begin
    repeat (3) @(negedge CLK);
    check_outputs_zero("por");
    RST = 1'b0;

    // Write then read back on port 0.
    access(0, 1'b1, 32'd5, 32'h00006000, 2);
    access(0, 1'b0, 32'd5, 32'h0, 2);

    // Simultaneous requests after reset: port 0 first.
    do_reset();
    fork
      access(0, 1'b0, 32'd3, 32'h0, 2);
      access(1, 1'b0, 32'd4, 32'h0, 5);
    join

    // Out-of-range write and the ALENGTH boundary.
    access(1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);
    access(0, 1'b1, 32'd127, 32'hA5A5_0127, 2);
    access(0, 1'b1, 32'd128, 32'h5A5A_0128, 2);

    // Continuous contention: grants alternate starting with port 0.
    do_reset();
    record_order = 1'b1;
    fork
      begin
        access(0, 1'b0, 32'd10, 32'h0, -1);
        access(0, 1'b1, 32'd11, 32'h1111_0011, -1);
      end
      begin
        access(1, 1'b1, 32'd70, 32'h7070_0070, -1);
        access(1, 1'b0, 32'd70, 32'h0, -1);
      end
    join
    record_order = 1'b0;
    chk("order_len", ack_order.size(), 4);
    for (int i = 0; i < ack_order.size() && i < 4; i++)
      chk($sformatf("order%0d", i), ack_order[i], i % 2);

    // Randomised traffic from both ports in disjoint address halves.
    fork
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(3, 0)) @(negedge CLK);
        access(0, 1'($urandom), rand_addr(0), $urandom, -1);
      end
      for (int j = 0; j < 25; j++) begin
        repeat ($urandom_range(3, 0)) @(negedge CLK);
        access(1, 1'($urandom), rand_addr(1), $urandom, -1);
      end
    join

    // Reset in the middle of a write's ACCESS cycle.
    begin
      int acks_before;
      @(negedge CLK);
      Req0 = 1'b1; We0 = 1'b1; Addr0 = 32'd20; WDat0 = 32'hDEAD_BEEF;
      @(posedge CLK);
      #1;
      chk("abort_we2_before", {31'b0, WE2}, 32'h1);
      RST = 1'b1;
      Req0 = 1'b0;
      #1;
      chk("abort_we2_async", {31'b0, WE2}, 32'h0);
      chk("abort_ack0_async", {31'b0, Ack0}, 32'h0);
      repeat (2) @(negedge CLK);
      check_outputs_zero("abort");
      RST = 1'b0;
      acks_before = ack_count;
      repeat (6) @(negedge CLK);
      chk("abort_no_ack", ack_count, acks_before);
      chk("abort_no_write", dmem[20], 32'h0);
    end

    chk("we2_total", we_total, exp_we_total);
    chk("scoreboard_empty", exp0.size() + exp1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
